// File: rtl/dspi_packet_arbiter_if.sv
// -----------------------------------------------------------------------------
// dspi_packet_arbiter_if
// One DSPI packet stream: the forward beat bundle, a per-beat Ready and the
// backward instruction channel. The master drives the forward bundle and
// listens to instructions; the slave consumes the bundle, drives Ready and
// issues instructions.
//
// Signals:
//   Data                 forward payload, DATA_WIDTH bits
//   Type                 2-bit beat type, 2'b00 means "no beat"
//   Last                 final beat of a packet
//   StreamID/ChunkID/ChannelID/State  forward side-band fields
//   Ready                slave accepted the offered beat this cycle
//   InstructionType      backward instruction (0 IDLE, 1 REQUEST, 2 REWIND,
//                        3 RESET)
//   InstructionParameter beat count carried by REQUEST
//
// The master modport carries no Ready: downstream flow control on this
// stream is credit based, so Ready is only meaningful towards requesters.
// -----------------------------------------------------------------------------
interface dspi_packet_arbiter_if #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_WIDTH             = 4,
  parameter int CHUNK_ID_WIDTH              = 5,
  parameter int CHANNEL_ID_WIDTH            = 10,
  parameter int STATE_WIDTH                 = 32,
  parameter int INSTRUCTION_WIDTH           = 2,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16
);

  logic [DATA_WIDTH-1:0]                  Data;
  logic [1:0]                             Type;
  logic                                   Last;
  logic [STREAM_ID_WIDTH-1:0]             StreamID;
  logic [CHUNK_ID_WIDTH-1:0]              ChunkID;
  logic [CHANNEL_ID_WIDTH-1:0]            ChannelID;
  logic [STATE_WIDTH-1:0]                 State;
  logic                                   Ready;
  logic [INSTRUCTION_WIDTH-1:0]           InstructionType;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] InstructionParameter;

  modport master (
    output Data, Type, Last, StreamID, ChunkID, ChannelID, State,
    input  InstructionType, InstructionParameter
  );

  modport slave (
    input  Data, Type, Last, StreamID, ChunkID, ChannelID, State,
    output Ready,
    output InstructionType, InstructionParameter
  );

endinterface

// File: rtl/dspi_packet_arbiter.sv
// -----------------------------------------------------------------------------
// dspi_packet_arbiter
// Merges two DSPI requester streams into one downstream stream. Grants are
// packet-atomic and alternate round-robin under contention; beats only move
// while the downstream credit counter is non-zero. Downstream replenishes
// credits with REQUEST instructions and clears them with RESET.
//
// Ports:
//   clk      sole clock, all state updates on posedge
//   rst      synchronous active-high reset
//   in0      slave stream from requester 0 (Ready combinational)
//   in1      slave stream from requester 1 (Ready combinational)
//   out      master stream to downstream, forward bundle registered,
//            backward instructions consumed here
//   credits  current downstream credit count
//   owner    one-hot current grant (01 = in0, 10 = in1, 00 = idle)
// -----------------------------------------------------------------------------
module dspi_packet_arbiter #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_WIDTH             = 4,
  parameter int CHUNK_ID_WIDTH              = 5,
  parameter int CHANNEL_ID_WIDTH            = 10,
  parameter int STATE_WIDTH                 = 32,
  parameter int INSTRUCTION_WIDTH           = 2,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter int CREDIT_WIDTH                = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  dspi_packet_arbiter_if.slave     in0,
  dspi_packet_arbiter_if.slave     in1,
  dspi_packet_arbiter_if.master    out,
  output logic [CREDIT_WIDTH-1:0]  credits,
  output logic [1:0]               owner
);

  // State encoding doubles as the one-hot owner value.
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] GRANT0 = 2'b01;
  localparam logic [1:0] GRANT1 = 2'b10;

  localparam logic [INSTRUCTION_WIDTH-1:0] INSTR_REQUEST = INSTRUCTION_WIDTH'(1);
  localparam logic [INSTRUCTION_WIDTH-1:0] INSTR_RESET   = INSTRUCTION_WIDTH'(3);

  // One extra bit over the wider operand holds credits + parameter without
  // wrapping, so saturation can be detected by a plain compare.
  localparam int SUM_WIDTH =
    ((CREDIT_WIDTH > INSTRUCTION_PARAMETER_WIDTH) ? CREDIT_WIDTH
                                                  : INSTRUCTION_PARAMETER_WIDTH) + 1;

  // Saturating credits + add - dec. dec is only set when a beat moved, which
  // requires credits != 0, so the subtraction cannot underflow.
  function automatic logic [CREDIT_WIDTH-1:0] satAddDec(
    input logic [CREDIT_WIDTH-1:0]                cur,
    input logic [INSTRUCTION_PARAMETER_WIDTH-1:0] add,
    input logic                                   dec
  );
    logic [SUM_WIDTH-1:0] sum;
    logic [SUM_WIDTH-1:0] maxVal;
    sum    = SUM_WIDTH'(cur) + SUM_WIDTH'(add) - SUM_WIDTH'(dec);
    maxVal = SUM_WIDTH'({CREDIT_WIDTH{1'b1}});
    if (sum > maxVal) begin
      return {CREDIT_WIDTH{1'b1}};
    end else begin
      return sum[CREDIT_WIDTH-1:0];
    end
  endfunction

  logic [1:0]              state_r;
  logic [1:0]              nextState_s;
  logic                    rrLast_r;
  logic                    nextRrLast_s;
  logic [CREDIT_WIDTH-1:0] credits_r;
  logic [CREDIT_WIDTH-1:0] nextCredits_s;

  logic valid0_s;
  logic valid1_s;
  logic creditsAvail_s;
  logic ready0_s;
  logic ready1_s;
  logic xfer0_s;
  logic xfer1_s;
  logic xferAny_s;

  logic [DATA_WIDTH-1:0]       selData_s;
  logic [1:0]                  selType_s;
  logic                        selLast_s;
  logic [STREAM_ID_WIDTH-1:0]  selStreamID_s;
  logic [CHUNK_ID_WIDTH-1:0]   selChunkID_s;
  logic [CHANNEL_ID_WIDTH-1:0] selChannelID_s;
  logic [STATE_WIDTH-1:0]      selState_s;

  logic [DATA_WIDTH-1:0]       outData_r;
  logic [1:0]                  outType_r;
  logic                        outLast_r;
  logic [STREAM_ID_WIDTH-1:0]  outStreamID_r;
  logic [CHUNK_ID_WIDTH-1:0]   outChunkID_r;
  logic [CHANNEL_ID_WIDTH-1:0] outChannelID_r;
  logic [STATE_WIDTH-1:0]      outState_r;

  // Data and control beats are treated alike: any non-zero Type is a beat.
  assign valid0_s = (in0.Type != 2'b00);
  assign valid1_s = (in1.Type != 2'b00);

  // Ready is purely a function of registered state, so it never depends on
  // the requester's own valid and cannot form a combinational loop.
  assign creditsAvail_s = (credits_r != {CREDIT_WIDTH{1'b0}});
  assign ready0_s       = (state_r == GRANT0) && creditsAvail_s && !rst;
  assign ready1_s       = (state_r == GRANT1) && creditsAvail_s && !rst;

  assign xfer0_s   = ready0_s && valid0_s;
  assign xfer1_s   = ready1_s && valid1_s;
  assign xferAny_s = xfer0_s || xfer1_s;

  assign in0.Ready = ready0_s;
  assign in1.Ready = ready1_s;

  // Backward instructions are terminated here; requesters never see any.
  assign in0.InstructionType      = {INSTRUCTION_WIDTH{1'b0}};
  assign in0.InstructionParameter = {INSTRUCTION_PARAMETER_WIDTH{1'b0}};
  assign in1.InstructionType      = {INSTRUCTION_WIDTH{1'b0}};
  assign in1.InstructionParameter = {INSTRUCTION_PARAMETER_WIDTH{1'b0}};

  // At most one input can transfer per cycle, so the grant alone selects.
  assign selData_s      = (state_r == GRANT1) ? in1.Data      : in0.Data;
  assign selType_s      = (state_r == GRANT1) ? in1.Type      : in0.Type;
  assign selLast_s      = (state_r == GRANT1) ? in1.Last      : in0.Last;
  assign selStreamID_s  = (state_r == GRANT1) ? in1.StreamID  : in0.StreamID;
  assign selChunkID_s   = (state_r == GRANT1) ? in1.ChunkID   : in0.ChunkID;
  assign selChannelID_s = (state_r == GRANT1) ? in1.ChannelID : in0.ChannelID;
  assign selState_s     = (state_r == GRANT1) ? in1.State     : in0.State;

  // Grant FSM next state and round-robin pointer.
  always_comb begin
    nextState_s  = state_r;
    nextRrLast_s = rrLast_r;
    case (state_r)
      IDLE: begin
        if (valid0_s && valid1_s) begin
          // Under contention the input that did not finish last wins.
          if (rrLast_r) begin
            nextState_s = GRANT0;
          end else begin
            nextState_s = GRANT1;
          end
        end else if (valid0_s) begin
          nextState_s = GRANT0;
        end else if (valid1_s) begin
          nextState_s = GRANT1;
        end else begin
          nextState_s = IDLE;
        end
      end
      GRANT0: begin
        // Only the Last beat releases the grant; stalls keep it.
        if (xfer0_s && in0.Last) begin
          nextState_s  = IDLE;
          nextRrLast_s = 1'b0;
        end else begin
          nextState_s = GRANT0;
        end
      end
      GRANT1: begin
        if (xfer1_s && in1.Last) begin
          nextState_s  = IDLE;
          nextRrLast_s = 1'b1;
        end else begin
          nextState_s = GRANT1;
        end
      end
      default: begin
        nextState_s = IDLE;
      end
    endcase
  end

  // Credit counter next value: RESET beats everything, REQUEST folds in the
  // same-cycle decrement before saturating.
  always_comb begin
    nextCredits_s = credits_r;
    if (out.InstructionType == INSTR_RESET) begin
      nextCredits_s = {CREDIT_WIDTH{1'b0}};
    end else if (out.InstructionType == INSTR_REQUEST) begin
      nextCredits_s = satAddDec(credits_r, out.InstructionParameter, xferAny_s);
    end else if (xferAny_s) begin
      nextCredits_s = credits_r - CREDIT_WIDTH'(1);
    end else begin
      nextCredits_s = credits_r;
    end
  end

  // Control state registers: FSM, round-robin pointer and credits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      rrLast_r  <= 1'b1;
      credits_r <= {CREDIT_WIDTH{1'b0}};
    end else begin
      state_r   <= nextState_s;
      rrLast_r  <= nextRrLast_s;
      credits_r <= nextCredits_s;
    end
  end

  // Output bundle register: capture a transferred beat, otherwise mark the
  // slot empty and leave the side-band fields as they were.
  always_ff @(posedge clk) begin
    if (rst) begin
      outData_r      <= {DATA_WIDTH{1'b0}};
      outType_r      <= 2'b00;
      outLast_r      <= 1'b0;
      outStreamID_r  <= {STREAM_ID_WIDTH{1'b0}};
      outChunkID_r   <= {CHUNK_ID_WIDTH{1'b0}};
      outChannelID_r <= {CHANNEL_ID_WIDTH{1'b0}};
      outState_r     <= {STATE_WIDTH{1'b0}};
    end else if (xferAny_s) begin
      outData_r      <= selData_s;
      outType_r      <= selType_s;
      outLast_r      <= selLast_s;
      outStreamID_r  <= selStreamID_s;
      outChunkID_r   <= selChunkID_s;
      outChannelID_r <= selChannelID_s;
      outState_r     <= selState_s;
    end else begin
      outType_r <= 2'b00;
    end
  end

  assign out.Data      = outData_r;
  assign out.Type      = outType_r;
  assign out.Last      = outLast_r;
  assign out.StreamID  = outStreamID_r;
  assign out.ChunkID   = outChunkID_r;
  assign out.ChannelID = outChannelID_r;
  assign out.State     = outState_r;

  assign credits = credits_r;
  assign owner   = state_r;

endmodule

// File: tb/tb_dspi_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dspi_packet_arbiter
// Each requester has a queue of beats; the front beat is offered every cycle.
// A small behavioural model predicts Ready, grant and credits; every beat the
// model says transfers is pushed to a scoreboard and popped when the DUT
// presents a non-empty beat on out. Directed scenarios add explicit checks.
// -----------------------------------------------------------------------------
module tb_dspi_packet_arbiter;

  localparam logic [1:0] I_IDLE    = 2'd0;
  localparam logic [1:0] I_REQUEST = 2'd1;
  localparam logic [1:0] I_RESET   = 2'd3;

  typedef struct packed {
    logic [511:0] data;
    logic [1:0]   typ;
    logic         last;
    logic [3:0]   sid;
    logic [4:0]   cid;
    logic [9:0]   chid;
    logic [31:0]  st;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [15:0] credits;
  logic [1:0]  owner;

  dspi_packet_arbiter_if in0If();
  dspi_packet_arbiter_if in1If();
  dspi_packet_arbiter_if outIf();

  // Downstream flow control is credit based; Ready on out is not used.
  assign outIf.Ready = 1'b0;

  dspi_packet_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .in0     (in0If),
    .in1     (in1If),
    .out     (outIf),
    .credits (credits),
    .owner   (owner)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t srcQ0[$];
  beat_t srcQ1[$];
  beat_t sbQ[$];
  int    outLog[$];

  int    errCnt = 0;
  int    chkCnt = 0;
  int    outBeats = 0;
  logic  pause0 = 1'b0;

  int    mState = 0;
  int    mRr = 1;
  int    mCred = 0;
  beat_t mHold = '0;
  beat_t lastOut = '0;

  task automatic checkVal(input string tag, input logic [511:0] got, input logic [511:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic addPkt(input int src, input int n, input logic [1:0] typ,
                        input logic [9:0] chid, input logic [31:0] st);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
      b.typ  = typ;
      b.last = (k == n - 1);
      b.sid  = 4'(src);
      b.cid  = 5'(k);
      b.chid = chid;
      b.st   = st;
      if (src == 0) srcQ0.push_back(b);
      else srcQ1.push_back(b);
    end
  endtask

  // One clock cycle: drive, check Ready, step the model, clock, check outputs.
  task automatic tick(input logic r, input logic [1:0] it, input logic [15:0] ip);
    beat_t b0, b1, e;
    logic  v0, v1, er0, er1, x0, x1;
    int    nc, expOwner;
    b0 = (srcQ0.size() != 0 && !pause0) ? srcQ0[0] : '0;
    b1 = (srcQ1.size() != 0) ? srcQ1[0] : '0;
    rst = r;
    outIf.InstructionType      = it;
    outIf.InstructionParameter = ip;
    in0If.Data = b0.data; in0If.Type = b0.typ; in0If.Last = b0.last;
    in0If.StreamID = b0.sid; in0If.ChunkID = b0.cid; in0If.ChannelID = b0.chid; in0If.State = b0.st;
    in1If.Data = b1.data; in1If.Type = b1.typ; in1If.Last = b1.last;
    in1If.StreamID = b1.sid; in1If.ChunkID = b1.cid; in1If.ChannelID = b1.chid; in1If.State = b1.st;
    #1;
    v0  = (b0.typ != 2'b00);
    v1  = (b1.typ != 2'b00);
    er0 = !r && (mState == 1) && (mCred != 0);
    er1 = !r && (mState == 2) && (mCred != 0);
    checkVal("in0Ready", in0If.Ready, er0);
    checkVal("in1Ready", in1If.Ready, er1);
    x0 = er0 && v0;
    x1 = er1 && v1;
    if (x0) begin sbQ.push_back(b0); srcQ0.delete(0); end
    if (x1) begin sbQ.push_back(b1); srcQ1.delete(0); end
    if (r) begin
      mState = 0; mRr = 1; mCred = 0; mHold = '0;
    end else begin
      if (it == I_RESET) mCred = 0;
      else if (it == I_REQUEST) begin
        nc = mCred + int'(ip) - ((x0 || x1) ? 1 : 0);
        mCred = (nc > 65535) ? 65535 : nc;
      end else if (x0 || x1) mCred = mCred - 1;
      case (mState)
        0: begin
          if (v0 && v1) mState = (mRr == 0) ? 2 : 1;
          else if (v0) mState = 1;
          else if (v1) mState = 2;
        end
        1: if (x0 && b0.last) begin mState = 0; mRr = 0; end
        2: if (x1 && b1.last) begin mState = 0; mRr = 1; end
        default: mState = 0;
      endcase
      if (x0) mHold = b0;
      if (x1) mHold = b1;
    end
    @(posedge clk);
    #1;
    expOwner = (mState == 1) ? 1 : (mState == 2) ? 2 : 0;
    checkVal("owner", owner, expOwner);
    checkVal("credits", credits, mCred);
    if (outIf.Type != 2'b00) begin
      if (sbQ.size() == 0) begin
        checkVal("unexpectedOut", outIf.Type, 2'b00);
      end else begin
        e = sbQ.pop_front();
        checkVal("outData", outIf.Data, e.data);
        checkVal("outType", outIf.Type, e.typ);
        checkVal("outLast", outIf.Last, e.last);
        checkVal("outStreamID", outIf.StreamID, e.sid);
        checkVal("outChunkID", outIf.ChunkID, e.cid);
        checkVal("outChannelID", outIf.ChannelID, e.chid);
        checkVal("outState", outIf.State, e.st);
        outBeats++;
        outLog.push_back(int'(outIf.StreamID));
        lastOut = e;
      end
    end else begin
      checkVal("holdData", outIf.Data, mHold.data);
      checkVal("holdChannelID", outIf.ChannelID, mHold.chid);
    end
    checkVal("sbLatency", sbQ.size(), 0);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && (srcQ0.size() != 0 || srcQ1.size() != 0); n++)
      tick(1'b0, I_IDLE, 16'd0);
    checkVal("drainTimeout", srcQ0.size() + srcQ1.size(), 0);
  endtask

  initial begin
    int mark;
    int expOrd[6] = '{0, 0, 1, 1, 0, 0};
    rst = 1'b1;
    outIf.InstructionType = I_IDLE;
    outIf.InstructionParameter = 16'd0;
    @(posedge clk);
    #1;

    // Reset state.
    tick(1'b1, I_REQUEST, 16'd7);
    tick(1'b1, I_IDLE, 16'd0);
    checkVal("rstOwner", owner, 2'b00);
    checkVal("rstCredits", credits, 16'd0);
    checkVal("rstType", outIf.Type, 2'b00);
    checkVal("rstLast", outIf.Last, 1'b0);
    checkVal("rstState", outIf.State, 32'd0);

    // Credit gating: 3 credits let exactly 3 of 5 beats through.
    addPkt(0, 5, 2'b01, 10'd1, 32'h1111_0000);
    tick(1'b0, I_IDLE, 16'd0);
    tick(1'b0, I_REQUEST, 16'd3);
    for (int i = 0; i < 6; i++) tick(1'b0, I_IDLE, 16'd0);
    checkVal("gate3Beats", outBeats, 3);
    checkVal("gateReady0", in0If.Ready, 1'b0);
    checkVal("gateOwner", owner, 2'b01);
    tick(1'b0, I_REQUEST, 16'd2);
    drain();
    checkVal("gate5Beats", outBeats, 5);
    checkVal("gateIdle", owner, 2'b00);

    // Latency and field integrity of a single-beat control packet on in1.
    tick(1'b0, I_REQUEST, 16'd1);
    addPkt(1, 1, 2'b10, 10'd5, 32'hDEAD_BEEF);
    drain();
    checkVal("ctlType", lastOut.typ, 2'b10);
    checkVal("ctlChannel", outIf.ChannelID, 10'd5);
    checkVal("ctlState", outIf.State, 32'hDEAD_BEEF);

    // Round-robin with both inputs offering 2-beat packets.
    tick(1'b0, I_REQUEST, 16'd100);
    outLog.delete();
    for (int p = 0; p < 3; p++) begin
      addPkt(0, 2, 2'b01, 10'd20, 32'h0);
      addPkt(1, 2, 2'b11, 10'd21, 32'h1);
    end
    drain();
    tick(1'b0, I_IDLE, 16'd0);
    checkVal("rrCount", outLog.size(), 12);
    for (int i = 0; i < 6; i++) checkVal("rrOrder", outLog[i], expOrd[i]);
    checkVal("rrCredits", credits, 16'd88);

    // Simultaneous REQUEST and transfer, then saturation.
    tick(1'b0, I_RESET, 16'd0);
    addPkt(0, 2, 2'b01, 10'd3, 32'h3);
    tick(1'b0, I_IDLE, 16'd0);
    tick(1'b0, I_REQUEST, 16'd1);
    tick(1'b0, I_REQUEST, 16'd4);
    checkVal("simReqXfer", credits, 16'd4);
    drain();
    tick(1'b0, I_RESET, 16'd0);
    tick(1'b0, I_REQUEST, 16'hFFFE);
    tick(1'b0, I_REQUEST, 16'd10);
    checkVal("saturate", credits, 16'hFFFF);
    tick(1'b0, I_RESET, 16'd0);

    // RESET instruction mid-packet keeps the grant; packet resumes later.
    addPkt(0, 4, 2'b01, 10'd4, 32'h4);
    tick(1'b0, I_REQUEST, 16'd5);
    tick(1'b0, I_IDLE, 16'd0);
    tick(1'b0, I_IDLE, 16'd0);
    pause0 = 1'b1;
    tick(1'b0, I_RESET, 16'd0);
    pause0 = 1'b0;
    checkVal("rstInstrCredits", credits, 16'd0);
    checkVal("rstInstrOwner", owner, 2'b01);
    mark = outBeats;
    for (int i = 0; i < 3; i++) tick(1'b0, I_IDLE, 16'd0);
    checkVal("rstInstrStall", outBeats, mark);
    addPkt(1, 3, 2'b01, 10'd6, 32'h6);
    outLog.delete();
    tick(1'b0, I_REQUEST, 16'd2);
    for (int i = 0; i < 4; i++) tick(1'b0, I_IDLE, 16'd0);
    checkVal("resumeCount", outLog.size(), 2);
    checkVal("resumeSrc0", outLog[0], 0);
    checkVal("resumeSrc1", outLog[1], 0);
    checkVal("g1Stall", owner, 2'b10);

    // rst pulsed during GRANT1 abandons the packet.
    tick(1'b0, I_REQUEST, 16'd5);
    tick(1'b0, I_IDLE, 16'd0);
    tick(1'b1, I_REQUEST, 16'd9);
    checkVal("midRstOwner", owner, 2'b00);
    checkVal("midRstCredits", credits, 16'd0);
    checkVal("midRstType", outIf.Type, 2'b00);
    srcQ1.delete();
    addPkt(0, 1, 2'b01, 10'd7, 32'h7);
    addPkt(1, 1, 2'b01, 10'd8, 32'h8);
    outLog.delete();
    tick(1'b0, I_REQUEST, 16'd10);
    drain();
    tick(1'b0, I_IDLE, 16'd0);
    checkVal("postRstCount", outLog.size(), 2);
    checkVal("postRstFirst", outLog[0], 0);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
